// File: rtl/ee354_gcd_pkg.sv
// Shared constants and one-hot state encoding for the ee354 GCD sweep driver.
package ee354_gcd_pkg;

    localparam int GCD_WIDTH_DEF = 8;
    localparam int GCD_CNT_W_DEF = 16;
    localparam int ST_W          = 8;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE      = 8'b0000_0001,
        ST_ISSUE     = 8'b0000_0010,
        ST_WAIT_SUB  = 8'b0000_0100,
        ST_WAIT_DONE = 8'b0000_1000,
        ST_REPORT    = 8'b0001_0000,
        ST_ACK       = 8'b0010_0000,
        ST_WAIT_I    = 8'b0100_0000,
        ST_FIN       = 8'b1000_0000
    } state_e;

endpackage

// File: rtl/ee354_gcd_sweep_driver_if.sv
// Result record port of the sweep driver: valid/ready handshake plus record fields.
interface ee354_gcd_sweep_driver_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;
    logic [WIDTH-1:0] res_gcd;
    logic [CNT_W-1:0] res_clks;

    modport master (
        output res_valid, res_a, res_b, res_gcd, res_clks,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_a, res_b, res_gcd, res_clks,
        output res_ready
    );
endinterface

// File: rtl/ee354_sat_counter.sv
// Clearable, enabled up-counter that sticks at all-ones; exposes its saturated increment.
module ee354_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_inc
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_inc;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt_q <= '0;
        else if (CEN)
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ee354_gcd_sweep_driver.sv
// Start/Ack initiator that sweeps (Ain,Bin) over [MIN_VAL..MAX_VAL] and reports timed GCD results.
// Optional watchdog enabled by defining GCD_SWEEP_TIMEOUT_EN.
module ee354_gcd_sweep_driver
    import ee354_gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH_DEF,
    parameter int MIN_VAL = 2,
    parameter int MAX_VAL = 63,
    parameter int CNT_W   = GCD_CNT_W_DEF,
    parameter int TIMEOUT = 1000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          CEN,
    input  logic                          Go,
    output logic [WIDTH-1:0]              Ain,
    output logic [WIDTH-1:0]              Bin,
    output logic                          Start,
    output logic                          Ack,
    input  logic                          q_I,
    input  logic                          q_Sub,
    input  logic                          q_Done,
    input  logic [WIDTH-1:0]              AB_GCD,
    ee354_gcd_sweep_driver_if.master      res,
    output logic                          busy,
    output logic                          sweep_done,
    output logic                          err
);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
`ifdef GCD_SWEEP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ain_q, ain_d, bin_q, bin_d;
    logic             start_q, start_d, ack_q, ack_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rg_q, rg_d;
    logic [CNT_W-1:0] rc_q, rc_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic             cnt_clr, cnt_en, timeout, tmo_hit;
    logic [CNT_W-1:0] cnt_inc;

    ee354_sat_counter #(.CNT_W(CNT_W)) u_clks (
        .Clk     (Clk),
        .Reset   (Reset),
        .CEN     (CEN),
        .clr     (cnt_clr),
        .inc     (cnt_en),
        .cnt_inc (cnt_inc)
    );

    assign tmo_hit = TMO_EN && (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d  = state_q;
        ain_d    = ain_q;
        bin_d    = bin_q;
        start_d  = 1'b0;
        ack_d    = 1'b0;
        rvalid_d = rvalid_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rg_d     = rg_q;
        rc_d     = rc_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: if (Go) begin
                ain_d   = MIN_V;
                bin_d   = MIN_V;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                cnt_clr = 1'b1;
                if (q_I) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT_SUB;
                end
            end
            ST_WAIT_SUB: begin
                // Done without a visible Sub phase is reported as zero clocks.
                if (q_Done) begin
                    rvalid_d = 1'b1;
                    ra_d     = ain_q;
                    rb_d     = bin_q;
                    rg_d     = AB_GCD;
                    rc_d     = '0;
                    state_d  = ST_REPORT;
                end else if (q_Sub) begin
                    cnt_clr = 1'b1;
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_en  = 1'b1;
                    timeout = tmo_hit;
                end
            end
            ST_WAIT_DONE: begin
                // Capture the post-increment count so clks spans the q_Sub and q_Done sample edges.
                if (q_Done) begin
                    rvalid_d = 1'b1;
                    ra_d     = ain_q;
                    rb_d     = bin_q;
                    rg_d     = AB_GCD;
                    rc_d     = cnt_inc;
                    state_d  = ST_REPORT;
                end else begin
                    cnt_en  = 1'b1;
                    timeout = tmo_hit;
                end
            end
            ST_REPORT: if (res.res_ready) begin
                rvalid_d = 1'b0;
                ack_d    = 1'b1;
                state_d  = ST_ACK;
            end
            ST_ACK: state_d = ST_WAIT_I;
            ST_WAIT_I: if (q_I) begin
                if (ain_q == MAX_V && bin_q == MAX_V) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_ISSUE;
                    if (bin_q == MAX_V) begin
                        bin_d = MIN_V;
                        ain_d = ain_q + WIDTH'(1);
                    end else begin
                        bin_d = bin_q + WIDTH'(1);
                    end
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Watchdog abandons the pair: Ack frees the core, no record is produced.
        if (timeout) begin
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_WAIT_I;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            ain_q    <= '0;
            bin_q    <= '0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            ra_q     <= '0;
            rb_q     <= '0;
            rg_q     <= '0;
            rc_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (CEN) begin
            state_q  <= state_d;
            ain_q    <= ain_d;
            bin_q    <= bin_d;
            start_q  <= start_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rg_q     <= rg_d;
            rc_q     <= rc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Ain          = ain_q;
    assign Bin          = bin_q;
    assign Start        = start_q;
    assign Ack          = ack_q;
    assign res.res_valid = rvalid_q;
    assign res.res_a    = ra_q;
    assign res.res_b    = rb_q;
    assign res.res_gcd  = rg_q;
    assign res.res_clks = rc_q;
    assign busy         = busy_q;
    assign sweep_done   = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_ee354_gcd_sweep_driver.sv
// Randomized bench for the sweep driver: behavioural GCD core, pair/record scoreboard, CEN and protocol monitors.
module tb_ee354_gcd_sweep_driver;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int MIN_V = 2;
    localparam int MAX_V = 3;
    localparam int TMO   = 50;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic CEN = 1'b1;
    logic Go = 1'b0;
    logic Start, Ack, q_I, q_Sub, q_Done, busy, sweep_done, err;
    logic [WIDTH-1:0] Ain, Bin, AB_GCD;

    ee354_gcd_sweep_driver_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) res_if ();

    ee354_gcd_sweep_driver #(
        .WIDTH(WIDTH), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .CNT_W(CNT_W), .TIMEOUT(TMO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .CEN(CEN), .Go(Go),
        .Ain(Ain), .Bin(Bin), .Start(Start), .Ack(Ack),
        .q_I(q_I), .q_Sub(q_Sub), .q_Done(q_Done), .AB_GCD(AB_GCD),
        .res(res_if), .busy(busy), .sweep_done(sweep_done), .err(err)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int nrec = 0;

    typedef struct packed { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } pair_t;
    pair_t exp_q[$];
    int    dq[$];

    function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic load_pairs();
        exp_q.delete();
        dq.delete();
        nrec = 0;
        for (int a = MIN_V; a <= MAX_V; a++)
            for (int b = MIN_V; b <= MAX_V; b++)
                exp_q.push_back({WIDTH'(a), WIDTH'(b)});
    endtask

    // Behavioural core: Sub lasts next_d enabled clocks (0 = straight to Done), Ack returns to Initial.
    typedef enum logic [1:0] {C_I, C_SUB, C_DONE} cst_e;
    cst_e cst;
    int   rem;
    int   next_d = 1;
    int   dmin = 0;
    bit   hang = 1'b0;
    logic [WIDTH-1:0] g_q;

    assign q_I    = (cst == C_I);
    assign q_Sub  = (cst == C_SUB);
    assign q_Done = (cst == C_DONE);
    assign AB_GCD = g_q;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cst <= C_I;
            rem <= 0;
            g_q <= '0;
        end else if (CEN) begin
            case (cst)
                C_I: if (Start) begin
                    g_q <= gcd_f(Ain, Bin);
                    rem <= next_d;
                    if (!hang) dq.push_back(next_d);
                    cst <= (next_d == 0 && !hang) ? C_DONE : C_SUB;
                end
                C_SUB: begin
                    if (Ack) cst <= C_I;
                    else if (!hang) begin
                        if (rem <= 1) cst <= C_DONE;
                        else rem <= rem - 1;
                    end
                end
                default: if (Ack) cst <= C_I;
            endcase
        end
    end

    initial forever begin
        @(negedge Clk);
        if (dmin > 0) next_d = $urandom_range(dmin + 4, dmin);
        else next_d = ($urandom_range(7) == 0) ? 0 : $urandom_range(6, 1);
    end

    // Input drivers change just after each rising edge.
    int cen_mode = 0;
    int rdy_mode = 0;
    initial begin
        res_if.res_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #2;
            case (cen_mode)
                0: CEN = 1'b1;
                1: CEN = ~CEN;
                default: CEN = 1'($urandom_range(1));
            endcase
            case (rdy_mode)
                0: res_if.res_ready = 1'b1;
                1: res_if.res_ready = 1'($urandom_range(1));
                default: res_if.res_ready = 1'b0;
            endcase
        end
    end

    logic [61:0] outs;
    assign outs = {Ain, Bin, Start, Ack, res_if.res_valid, res_if.res_a, res_if.res_b,
                   res_if.res_gcd, res_if.res_clks, busy, sweep_done, err};

    // Scoreboard and protocol monitors, sampled on the falling edge.
    initial begin
        pair_t p;
        int d;
        logic [61:0] snap;
        bit prev_cen, prev_rst, start_prev_en;
        snap = '0;
        prev_cen = 1'b1;
        prev_rst = 1'b1;
        start_prev_en = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset && !prev_rst && !prev_cen) begin
                vectors++;
                if (outs !== snap) begin
                    miscompares++;
                    $display("FAIL cen_hold: outputs %h, required held %h", outs, snap);
                end
            end
            if (!Reset) begin
                vectors++;
                if (Start && Ack) begin
                    miscompares++;
                    $display("FAIL start_ack_overlap: Start=%b Ack=%b, required not both 1", Start, Ack);
                end
            end
            if (Reset) start_prev_en = 1'b0;
            else if (CEN) begin
                if (Start && start_prev_en) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL start_width: Start high on 2 enabled clocks, required 1");
                end
                start_prev_en = Start;
            end
            if (!Reset && CEN && res_if.res_valid && res_if.res_ready) begin
                vectors++;
                nrec++;
                if (exp_q.size() == 0 || dq.size() == 0) begin
                    miscompares++;
                    $display("FAIL record_extra: got a=%0d b=%0d, required no record", res_if.res_a, res_if.res_b);
                end else begin
                    p = exp_q.pop_front();
                    d = dq.pop_front();
                    if ({res_if.res_a, res_if.res_b, res_if.res_gcd, res_if.res_clks} !==
                        {p.a, p.b, gcd_f(p.a, p.b), CNT_W'(d)}) begin
                        miscompares++;
                        $display("FAIL record: got (%0d,%0d,gcd %0d,clks %0d), required (%0d,%0d,gcd %0d,clks %0d)",
                                 res_if.res_a, res_if.res_b, res_if.res_gcd, res_if.res_clks,
                                 p.a, p.b, gcd_f(p.a, p.b), d);
                    end
                end
            end
            snap = outs;
            prev_cen = CEN;
            prev_rst = Reset;
        end
    end

    task automatic pulse_go();
        @(posedge Clk); #2 Go = 1'b1;
        @(posedge Clk); #2 Go = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!(sweep_done === 1'b1 && busy === 1'b0) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s: sweep_done=%b busy=%b after %0d clks, required 1/0", nm, sweep_done, busy, budget);
        end
    endtask

    task automatic check_sweep_end(input int want_rec, input string nm);
        vectors++;
        if (nrec !== want_rec || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_records: got %0d records (%0d pairs left), required %0d (0 left)",
                     nm, nrec, exp_q.size(), want_rec);
        end
        vectors++;
        if ({busy, sweep_done} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s_flags: busy/sweep_done=%b%b, required 01", nm, busy, sweep_done);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required all zero", outs);
        end
        @(posedge Clk); #2 Reset = 1'b0;
        @(negedge Clk);
        vectors++;
        if ({Start, Ack, busy, res_if.res_valid} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: Start/Ack/busy/valid=%b, required 0000",
                     {Start, Ack, busy, res_if.res_valid});
        end
    endtask

    task automatic test_sweep();
        load_pairs();
        rdy_mode = 0;
        pulse_go();
        @(negedge Clk);
        vectors++;
        if ({busy, sweep_done, Ain, Bin} !== {2'b10, WIDTH'(MIN_V), WIDTH'(MIN_V)}) begin
            miscompares++;
            $display("FAIL go_start: busy=%b done=%b Ain=%0d Bin=%0d, required 1 0 %0d %0d",
                     busy, sweep_done, Ain, Bin, MIN_V, MIN_V);
        end
        wait_done(2000, "sweep");
        check_sweep_end(4, "sweep");
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_idle: err=%b, required 0", err);
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] held;
        int n = 0;
        load_pairs();
        rdy_mode = 2;
        pulse_go();
        while (res_if.res_valid !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL bp_first_valid: res_valid not seen, required within 200 clks");
        end
        held = {res_if.res_a, res_if.res_b, res_if.res_gcd, res_if.res_clks};
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            vectors++;
            if ({res_if.res_valid, Ack, res_if.res_a, res_if.res_b, res_if.res_gcd, res_if.res_clks} !==
                {2'b10, held}) begin
                miscompares++;
                $display("FAIL bp_stall: valid=%b Ack=%b rec=%h, required 1 0 %h",
                         res_if.res_valid, Ack, {res_if.res_a, res_if.res_b, res_if.res_gcd, res_if.res_clks}, held);
            end
        end
        rdy_mode = 0;
        @(negedge Clk);
        vectors++;
        if (Ack !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ack_early: Ack=%b, required 0 before accept", Ack);
        end
        @(negedge Clk);
        vectors++;
        if ({Ack, res_if.res_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_ack: Ack/valid=%b%b, required 10", Ack, res_if.res_valid);
        end
        @(negedge Clk);
        vectors++;
        if (Ack !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ack_width: Ack=%b, required 0 on second clock", Ack);
        end
        rdy_mode = 1;
        wait_done(3000, "bp");
        check_sweep_end(4, "bp");
        rdy_mode = 0;
    endtask

    task automatic test_cen();
        load_pairs();
        cen_mode = 0;
        @(negedge Clk);
        pulse_go();
        cen_mode = 1;
        wait_done(4000, "cen");
        cen_mode = 0;
        repeat (2) @(negedge Clk);
        check_sweep_end(4, "cen");
        load_pairs();
        pulse_go();
        cen_mode = 2;
        rdy_mode = 1;
        wait_done(6000, "cen_rand");
        cen_mode = 0;
        rdy_mode = 0;
        repeat (2) @(negedge Clk);
        check_sweep_end(4, "cen_rand");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        load_pairs();
        dmin = 5;
        pulse_go();
        while (q_Sub !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if ({Start, Ack, res_if.res_valid, busy, sweep_done, Ain, Bin} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: Start/Ack/valid/busy/done=%b Ain=%0d Bin=%0d, required all 0",
                     {Start, Ack, res_if.res_valid, busy, sweep_done}, Ain, Bin);
        end
        dmin = 0;
        @(posedge Clk); #2 Reset = 1'b0;
        load_pairs();
        pulse_go();
        n = 0;
        while (Start !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        vectors++;
        if ({Start, Ain, Bin} !== {1'b1, WIDTH'(MIN_V), WIDTH'(MIN_V)}) begin
            miscompares++;
            $display("FAIL restart_pair: Start=%b Ain=%0d Bin=%0d, required 1 %0d %0d",
                     Start, Ain, Bin, MIN_V, MIN_V);
        end
        wait_done(2000, "restart");
        check_sweep_end(4, "restart");
    endtask

    task automatic test_go_busy();
        int n = 0;
        load_pairs();
        rdy_mode = 1;
        pulse_go();
        while (sweep_done !== 1'b1 && n < 3000) begin
            @(posedge Clk);
            #2 Go = busy && ($urandom_range(2) == 0);
            n++;
        end
        Go = 1'b0;
        rdy_mode = 0;
        vectors++;
        if (n >= 3000) begin
            miscompares++;
            $display("FAIL go_busy_done: sweep_done not seen, required within 3000 clks");
        end
        repeat (20) @(negedge Clk);
        check_sweep_end(4, "go_busy");
    endtask

`ifdef GCD_SWEEP_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        int k = 0;
        int acks = 0;
        pair_t skipped;
        load_pairs();
        hang = 1'b1;
        pulse_go();
        while (q_Sub !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        // The driver samples q_Sub on the next edge; err lands TMO edges after that.
        while (err !== 1'b1 && k < 200) begin
            @(negedge Clk);
            k++;
            if (Ack === 1'b1) acks++;
        end
        hang = 1'b0;
        skipped = exp_q.pop_front();
        vectors++;
        if (k !== TMO + 1) begin
            miscompares++;
            $display("FAIL timeout_clks: err after %0d clks, required %0d", k - 1, TMO);
        end
        vectors++;
        if ({Ack, res_if.res_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_ack: Ack/valid=%b%b, required 10", Ack, res_if.res_valid);
        end
        n = 0;
        while (Start !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
            if (Ack === 1'b1) acks++;
        end
        vectors++;
        if (acks !== 1 || {Ain, Bin} !== {skipped.a, skipped.b + WIDTH'(1)}) begin
            miscompares++;
            $display("FAIL timeout_next: acks=%0d next=(%0d,%0d), required 1 (%0d,%0d)",
                     acks, Ain, Bin, skipped.a, skipped.b + WIDTH'(1));
        end
        wait_done(2000, "timeout");
        check_sweep_end(3, "timeout");
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_reset: err=%b, required 0", err);
        end
        @(posedge Clk); #2 Reset = 1'b0;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_cen();
        test_reset_mid();
        test_go_busy();
`ifdef GCD_SWEEP_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
